// File: rtl/interval_timer_16.sv
// interval_timer_16: measures prescaled ticks between a rising edge on start
// and a rising edge on stop, holding the 16-bit result for display.
module interval_timer_16 #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] elapsed,
    output logic        valid,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        DONE
    } state_t;

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    state_t      state;
    logic [15:0] prescaler;
    logic [15:0] count;
    logic        start_q;
    logic        stop_q;
    logic        start_edge;
    logic        stop_edge;

    assign start_edge = start & ~start_q;
    assign stop_edge  = stop & ~stop_q;

    // Edge detectors, measurement FSM, tick counter and registered outputs.
    // Start has priority over a coincident stop outside RUNNING; inside
    // RUNNING a start edge is ignored so stop always completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prescaler <= '0;
            count     <= '0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            elapsed   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state     <= RUNNING;
                        prescaler <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                        valid     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (stop_edge) begin
                        // The tick boundary coincident with stop is not counted.
                        state   <= DONE;
                        elapsed <= count;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                    end else if (prescaler == PRESCALE_LAST) begin
                        prescaler <= '0;
                        if (count == '1) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + 16'd1;
                        end
                    end else begin
                        prescaler <= prescaler + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/interval_timer_16.md
Name: interval_timer_16

Overview:
- Measures the time between a start event and a stop event, in prescaled ticks. This is the measuring counterpart of the trigger-to-timeout delay generator.
- Typical use is reaction-time capture: the delay generator lights the LED and drives start; the user button drives stop.
- The result is a 16-bit tick count, held for display until the next measurement begins.

Parameters:
- PRESCALE, 50000, clk cycles per tick (1 ms at 50 MHz); legal range 2..65535.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level input; its rising edge begins a measurement.
- stop  input  1  level input; its rising edge ends a measurement.
- elapsed  output  16  latched tick count of the last completed measurement.
- valid  output  1  high while elapsed holds a completed result.
- busy  output  1  high while measuring.
- overflow  output  1  high if the count saturated during the current or last measurement.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; prescaler=0; count=0.
  - elapsed=16'h0000; valid=0; busy=0; overflow=0.
  - Edge-detect registers start_q and stop_q = 0.
  - Consequence: start held high across reset release produces an edge on the first clock.
- Edge detection:
  - start_edge = start & ~start_q; stop_edge = stop & ~stop_q.
  - start_q/stop_q update every clock in every state.
  - Inputs are assumed already synchronised upstream.
- States: IDLE, RUNNING, DONE. busy is 1 only in RUNNING.
- IDLE:
  - start_edge → RUNNING; prescaler<=0, count<=0, overflow<=0, valid<=0.
  - stop_edge is ignored.
  - start_edge and stop_edge in the same cycle: start wins, stop is ignored.
- RUNNING, each clock without stop_edge:
  - If prescaler==PRESCALE-1: prescaler<=0 and count<=count+1, saturating at 16'hFFFF.
  - When the increment is attempted at 16'hFFFF, count holds and overflow<=1 (sticky until the next start).
  - Otherwise prescaler<=prescaler+1.
- RUNNING, stop_edge:
  - state<=DONE; elapsed<=count as it stands before this clock (the tick boundary coincident with stop is not counted); valid<=1.
  - Result: elapsed = min(floor((t_stop - t_start - 1)/PRESCALE), 65535), where t_* are the clock edges at which each edge is detected.
  - start_edge in RUNNING is ignored (no restart), including when coincident with stop_edge; stop still completes.
- DONE:
  - elapsed, valid and overflow hold.
  - stop_edge is ignored.
  - start_edge → RUNNING with the same clearing as from IDLE; valid drops on that clock and elapsed keeps its old value until overwritten.
- Latency:
  - busy rises one clock after start_edge is sampled.
  - valid and elapsed update on the clock that samples stop_edge; no extra pipeline stage.
- Reset mid-measurement: immediate return to IDLE with all outputs cleared; no partial result is retained.
- Widths: prescaler is 16 bits; count and elapsed are 16 bits unsigned.

Test Plan:
- PRESCALE=4; reset; start rises at cycle 0, stop rises at cycle 41 → busy 1 over cycles 1..41; at cycle 41 elapsed=10, valid=1, overflow=0.
- PRESCALE=4; stop rises at cycle 40 (exact tick boundary) → elapsed=9; stop at cycle 1 → elapsed=0, valid=1.
- PRESCALE=2; run without stop for more than 65535×2 cycles → overflow=1; stop → elapsed=16'hFFFF, valid=1.
- Second start pulse while RUNNING, and start/stop rising together in IDLE → the measurement is not restarted; the IDLE case enters RUNNING with busy=1.
- DONE holding elapsed=10, then a new start → valid=0 next cycle; elapsed stays 10 until the next stop, then updates; an extra stop in DONE is ignored.
- Assert reset_n low asynchronously mid-RUNNING (between clock edges) → outputs zero immediately; start held high at release → measurement begins on the first clock.
